// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel window feeder: kernel geometry, FSM states
// and the window element index helper.
package pixel_pkg;

    localparam int unsigned K             = 3;
    localparam int unsigned PIX_W_DEFAULT = 8;
    localparam int unsigned KC_W          = $clog2(K);
    localparam int unsigned KIDX_W        = $clog2(K * K);

    typedef enum logic [2:0] {
        StWaitPush,
        StFetch,
        StDrain,
        StFull,
        StWaitLow,
        StDone
    } state_e;

    function automatic logic [KIDX_W-1:0] win_idx(input logic [KC_W-1:0] kr,
                                                  input logic [KC_W-1:0] kc);
        return KIDX_W'(kr) * KIDX_W'(K) + KIDX_W'(kc);
    endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// Position and kernel counters for the window feeder; produces the image memory
// read address with a running row base instead of a multiplier.
module pixel_addr_gen
    import pixel_pkg::*;
#(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              step_k,
    input  logic              advance,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pos_row,
    output logic [ADDR_W-1:0] pos_col,
    output logic [KC_W-1:0]   kr,
    output logic [KC_W-1:0]   kc,
    output logic              k_last,
    output logic              pos_last
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(IMG_H - K);
    localparam logic [KC_W-1:0]   K_MAX    = KC_W'(K - 1);

    logic [ADDR_W-1:0] row_base_q, krow_base_q, pos_row_q, pos_col_q;
    logic [KC_W-1:0]   kr_q, kc_q;

    assign k_last   = (kr_q == K_MAX) && (kc_q == K_MAX);
    assign pos_last = (pos_row_q == ROW_MAX) && (pos_col_q == COL_MAX);
    // krow_base_q tracks (pos_row + kr) * IMG_W
    assign mem_addr = krow_base_q + pos_col_q + ADDR_W'(kc_q);
    assign pos_row  = pos_row_q;
    assign pos_col  = pos_col_q;
    assign kr       = kr_q;
    assign kc       = kc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || restart) begin
            row_base_q  <= '0;
            krow_base_q <= '0;
            pos_row_q   <= '0;
            pos_col_q   <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
        end else if (step_k) begin
            if (kc_q == K_MAX) begin
                kc_q <= '0;
                if (kr_q == K_MAX) begin
                    kr_q        <= '0;
                    krow_base_q <= row_base_q;
                end else begin
                    kr_q        <= kr_q + 1'b1;
                    krow_base_q <= krow_base_q + ROW_STEP;
                end
            end else begin
                kc_q <= kc_q + 1'b1;
            end
        end else if (advance) begin
            if (pos_col_q == COL_MAX) begin
                pos_col_q <= '0;
                if (pos_row_q == ROW_MAX) begin
                    pos_row_q   <= '0;
                    row_base_q  <= '0;
                    krow_base_q <= '0;
                end else begin
                    pos_row_q   <= pos_row_q + 1'b1;
                    row_base_q  <= row_base_q + ROW_STEP;
                    krow_base_q <= row_base_q + ROW_STEP;
                end
            end else begin
                pos_col_q <= pos_col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_window_feeder.sv
// Fetches K x K pixel neighbourhoods from synchronous-read memory on each
// pushpixel request and holds them for the MAC and writeback phases.
module pixel_window_feeder
    import pixel_pkg::*;
#(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned PIX_W  = PIX_W_DEFAULT,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   pushpixel,
    output logic                   filled,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [PIX_W-1:0]       mem_data,
    output logic [K*K*PIX_W-1:0]   window,
    output logic [ADDR_W-1:0]      pos_row,
    output logic [ADDR_W-1:0]      pos_col,
    output logic                   frame_done
);

    state_e                state_q;
    logic                  filled_q, mem_rd_q, frame_done_q, was_last_q;
    logic                  cap_valid_q;
    logic [KIDX_W-1:0]     cap_idx_q;
    logic [K*K*PIX_W-1:0]  window_q;
    logic [KC_W-1:0]       kr, kc;
    logic                  k_last, pos_last, step_k, advance;

    assign step_k  = (state_q == StFetch) && !frame_start;
    assign advance = (state_q == StFull) && !frame_start;

    pixel_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .restart  (frame_start),
        .step_k   (step_k),
        .advance  (advance),
        .mem_addr (mem_addr),
        .pos_row  (pos_row),
        .pos_col  (pos_col),
        .kr       (kr),
        .kc       (kc),
        .k_last   (k_last),
        .pos_last (pos_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StWaitPush;
            filled_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            frame_done_q <= 1'b0;
            was_last_q   <= 1'b0;
        end else if (frame_start) begin
            state_q      <= StWaitLow;
            filled_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            frame_done_q <= 1'b0;
            was_last_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StWaitPush: begin
                    if (pushpixel) begin
                        state_q  <= StFetch;
                        mem_rd_q <= 1'b1;
                    end
                end
                StFetch: begin
                    if (k_last) begin
                        state_q  <= StDrain;
                        mem_rd_q <= 1'b0;
                    end
                end
                StDrain: begin
                    state_q  <= StFull;
                    filled_q <= 1'b1;
                end
                StFull: begin
                    state_q    <= StWaitLow;
                    filled_q   <= 1'b0;
                    was_last_q <= pos_last;
                end
                StWaitLow: begin
                    if (!pushpixel) begin
                        if (was_last_q) begin
                            state_q      <= StDone;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= StWaitPush;
                        end
                    end
                end
                StDone: ;
                default: state_q <= StWaitPush;
            endcase
        end
    end

    // Read data arrives one cycle after the strobe, so the element index is delayed to match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            window_q    <= '0;
        end else begin
            cap_valid_q <= mem_rd_q && !frame_start;
            cap_idx_q   <= win_idx(kr, kc);
            if (cap_valid_q && !frame_start) begin
                window_q[int'(cap_idx_q) * PIX_W +: PIX_W] <= mem_data;
            end
        end
    end

    assign filled     = filled_q;
    assign mem_rd     = mem_rd_q;
    assign frame_done = frame_done_q;
    assign window     = window_q;

endmodule

// File: tb/tb_pixel_window_feeder.sv
// Self-checking bench for pixel_window_feeder on a 5x4 image with a 3x3 kernel,
// using a behavioural memory and window model.
module tb_pixel_window_feeder;

    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 5;
    localparam int KS     = 3;
    localparam int NCOL   = IMG_W - KS + 1;
    localparam int NROW   = IMG_H - KS + 1;
    localparam int NPOS   = NCOL * NROW;
    localparam int WIN_W  = KS * KS * PIX_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              pushpixel;
    logic              filled;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    logic [WIN_W-1:0]  window;
    logic [ADDR_W-1:0] pos_row;
    logic [ADDR_W-1:0] pos_col;
    logic              frame_done;

    logic [PIX_W-1:0]  mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    pixel_window_feeder #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pushpixel   (pushpixel),
        .filled      (filled),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .window      (window),
        .pos_row     (pos_row),
        .pos_col     (pos_col),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] exp_window(input int r, input int c);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int kr = 0; kr < KS; kr++)
            for (int kc = 0; kc < KS; kc++)
                w[(kr*KS + kc)*PIX_W +: PIX_W] = mem[(r + kr)*IMG_W + c + kc];
        return w;
    endfunction

    // One full request for position p; pushpixel drops at cycle 'hold' after E0.
    task automatic request(input int p, input int hold);
        int r, c, nrd, nfill, fcyc, mon, exp_addr;
        r = p / NCOL;
        c = p % NCOL;
        mon = (hold > 20) ? hold : 20;
        nrd = 0; nfill = 0; fcyc = 0;
        @(negedge clk);
        pushpixel = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= mon; cyc++) begin
            @(negedge clk);
            if (cyc >= hold) pushpixel = 1'b0;
            if (mem_rd) begin
                if (nrd < 9) begin
                    exp_addr = (r + nrd/KS)*IMG_W + c + nrd%KS;
                    check("mem_addr", mem_addr, exp_addr);
                    check("rd_cycle", cyc, nrd + 1);
                end
                nrd++;
            end
            if (filled) begin
                nfill++;
                fcyc = cyc;
                check("window", window, exp_window(r, c));
                check("pos_row", pos_row, r);
                check("pos_col", pos_col, c);
            end
        end
        check("rd_count", nrd, 9);
        check("fill_count", nfill, 1);
        check("fill_cycle", fcyc, 11);
        check("window_hold", window, exp_window(r, c));
        pushpixel = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_filled"}, filled, 1'b0);
        check({tag, "_mem_rd"}, mem_rd, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_window"}, window, 0);
        check({tag, "_pos_row"}, pos_row, 0);
        check({tag, "_pos_col"}, pos_col, 0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    initial begin
        int nrd, nfill;
        rst = 1'b1;
        frame_start = 1'b0;
        pushpixel = 1'b0;
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = PIX_W'(a);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full frame of directed requests with address-valued memory.
        for (int p = 0; p < NPOS; p++) request(p, 20);
        check("frame_done_set", frame_done, 1'b1);

        // Requests after frame end must be ignored.
        nrd = 0; nfill = 0;
        pushpixel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_rd) nrd++;
            if (filled) nfill++;
        end
        pushpixel = 1'b0;
        check("done_no_rd", nrd, 0);
        check("done_no_fill", nfill, 0);

        pulse_frame_start();
        check("restart_frame_done", frame_done, 1'b0);
        check("restart_pos_row", pos_row, 0);
        check("restart_pos_col", pos_col, 0);
        repeat (2) @(negedge clk);
        request(0, 20);

        // Held request: exactly one fetch.
        request(1, 40);

        // frame_start together with pushpixel: request dropped.
        @(negedge clk);
        frame_start = 1'b1;
        pushpixel = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        nrd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_rd) nrd++;
        end
        pushpixel = 1'b0;
        check("fs_push_no_rd", nrd, 0);
        repeat (2) @(negedge clk);
        request(0, 20);

        // Abort in cycle 4 of FETCH.
        @(negedge clk);
        pushpixel = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pushpixel = 1'b0;
        check("abort_mem_rd", mem_rd, 1'b0);
        nfill = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (filled) nfill++;
            if (mem_rd) nfill++;
        end
        check("abort_no_activity", nfill, 0);
        check("abort_pos_row", pos_row, 0);
        check("abort_pos_col", pos_col, 0);
        request(0, 20);
        request(1, 20);

        // Reset asserted mid-fetch.
        @(negedge clk);
        pushpixel = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        pushpixel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        request(0, 20);

        // Randomized frames: random pixel data, hold lengths and gaps.
        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = PIX_W'($urandom_range(0, 255));
            pulse_frame_start();
            repeat (2) @(negedge clk);
            for (int p = 0; p < NPOS; p++) begin
                request(p, int'($urandom_range(1, 30)));
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
            check("rand_frame_done", frame_done, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
